// File: rtl/onchip_mem_arbiter.sv
// Round-robin arbiter that lets two Avalon-MM requesters share one single-port
// on-chip RAM, returning reads one cycle after acceptance.
module onchip_mem_arbiter #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16,
  parameter int BE_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,

  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,

  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,

  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata,

  output logic [CNT_W-1:0]  contention_count,
  input  logic              contention_clear
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             req0;
  logic             req1;
  logic             grant0;
  logic             grant1;
  logic             contend;

  logic             last_grant_q, last_grant_d;
  logic             rd_pending_q, rd_pending_d;
  logic             rd_owner_q,   rd_owner_d;
  logic [CNT_W-1:0] cnt_q,        cnt_d;

  // A simultaneous read+write is a write, so req only needs the OR.
  assign req0    = m0_read | m0_write;
  assign req1    = m1_read | m1_write;
  assign contend = req0 & req1;

  // Grant: a lone requester wins; on conflict the one not granted last wins.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (reset) begin
      grant0 = 1'b0;
      grant1 = 1'b0;
    end else if (contend) begin
      if (last_grant_q) begin
        grant0 = 1'b1;
      end else begin
        grant1 = 1'b1;
      end
    end else if (req0) begin
      grant0 = 1'b1;
    end else if (req1) begin
      grant1 = 1'b1;
    end else begin
      grant0 = 1'b0;
      grant1 = 1'b0;
    end
  end

  // Requester handshake and read return
  always_comb begin
    m0_waitrequest   = 1'b1;
    m1_waitrequest   = 1'b1;
    if (reset) begin
      m0_waitrequest = 1'b1;
      m1_waitrequest = 1'b1;
    end else begin
      m0_waitrequest = req0 & ~grant0;
      m1_waitrequest = req1 & ~grant1;
    end
    m0_readdatavalid = rd_pending_q & ~rd_owner_q;
    m1_readdatavalid = rd_pending_q &  rd_owner_q;
    m0_readdata      = mem_readdata;
    m1_readdata      = mem_readdata;
  end

  // RAM port mux; an idle cycle leaves the m0 path selected.
  always_comb begin
    mem_address    = m0_address;
    mem_byteenable = m0_byteenable;
    mem_writedata  = m0_writedata;
    if (grant1) begin
      mem_address    = m1_address;
      mem_byteenable = m1_byteenable;
      mem_writedata  = m1_writedata;
    end else begin
      mem_address    = m0_address;
      mem_byteenable = m0_byteenable;
      mem_writedata  = m0_writedata;
    end
    mem_chipselect = grant0 | grant1;
    mem_write      = (grant0 & m0_write) | (grant1 & m1_write);
    mem_clken      = ~reset;
  end

  // Next-state for arbitration history, read tracking and contention counter
  always_comb begin
    last_grant_d = last_grant_q;
    rd_pending_d = 1'b0;
    rd_owner_d   = rd_owner_q;
    cnt_d        = cnt_q;

    if (grant1) begin
      last_grant_d = 1'b1;
    end else if (grant0) begin
      last_grant_d = 1'b0;
    end else begin
      last_grant_d = last_grant_q;
    end

    if (grant0 && !m0_write) begin
      rd_pending_d = 1'b1;
      rd_owner_d   = 1'b0;
    end else if (grant1 && !m1_write) begin
      rd_pending_d = 1'b1;
      rd_owner_d   = 1'b1;
    end else begin
      rd_pending_d = 1'b0;
      rd_owner_d   = rd_owner_q;
    end

    // Clear outranks a same-cycle increment.
    if (contention_clear) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (contend && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers; last_grant resets to m1 so m0 wins the first conflict.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_q <= 1'b1;
      rd_pending_q <= 1'b0;
      rd_owner_q   <= 1'b0;
      cnt_q        <= {CNT_W{1'b0}};
    end else begin
      last_grant_q <= last_grant_d;
      rd_pending_q <= rd_pending_d;
      rd_owner_q   <= rd_owner_d;
      cnt_q        <= cnt_d;
    end
  end

  assign contention_count = cnt_q;

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Directed bench for onchip_mem_arbiter with a behavioural 2048x32 byte-enabled
// RAM (registered address, one-cycle read latency).
module tb_onchip_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] m0_address, m1_address;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic [31:0] m0_writedata, m1_writedata;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic [10:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect, mem_write, mem_clken;
  logic [31:0] mem_writedata, mem_readdata;
  logic [15:0] contention_count;
  logic        contention_clear;

  logic [31:0] ram [0:2047];
  logic [31:0] ram_rd;
  logic        pl_en;
  logic [10:0] pl_addr;
  logic [31:0] pl_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  onchip_mem_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_byteenable(m0_byteenable), .m0_writedata(m0_writedata),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_byteenable(m1_byteenable), .m1_writedata(m1_writedata),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata),
    .contention_count(contention_count), .contention_clear(contention_clear)
  );

  // RAM model; the preload port lets the bench seed contents during reset.
  always @(posedge clk) begin
    if (pl_en) begin
      ram[pl_addr] <= pl_data;
    end else if (mem_clken && mem_chipselect) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
        end
      end else begin
        ram_rd <= ram[mem_address];
      end
    end
  end
  assign mem_readdata = ram_rd;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_read = 1'b0; m0_write = 1'b0; m1_read = 1'b0; m1_write = 1'b0;
    m0_address = 11'h000; m1_address = 11'h000;
    m0_byteenable = 4'hF; m1_byteenable = 4'hF;
    m0_writedata = 32'h0; m1_writedata = 32'h0;
    contention_clear = 1'b0;
  endtask

  task automatic apply_reset();
    step();
    reset = 1'b1;
    idle_inputs();
    step();
    reset = 1'b0;
  endtask

  task automatic preload(input logic [10:0] a, input logic [31:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    step();
    pl_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    pl_en = 1'b0; pl_addr = 11'h000; pl_data = 32'h0;
    idle_inputs();
    preload(11'h005, 32'hDEADBEEF);
    preload(11'h7FF, 32'hFFFFFFFF);
    preload(11'h010, 32'h11110010);
    preload(11'h020, 32'h22220020);

    // Reset state
    #4;
    check_eq("rst_m0_wait", {31'd0, m0_waitrequest}, 32'd1);
    check_eq("rst_m1_wait", {31'd0, m1_waitrequest}, 32'd1);
    check_eq("rst_clken",   {31'd0, mem_clken},      32'd0);
    check_eq("rst_cs",      {31'd0, mem_chipselect}, 32'd0);
    check_eq("rst_cnt",     {16'd0, contention_count}, 32'd0);
    step();
    reset = 1'b0;

    // Single m0 read of 0x005
    m0_read = 1'b1; m0_address = 11'h005;
    #4;
    check_eq("rd_m0_wait",  {31'd0, m0_waitrequest}, 32'd0);
    check_eq("rd_cs",       {31'd0, mem_chipselect}, 32'd1);
    check_eq("rd_addr",     {21'd0, mem_address},    32'h005);
    step();
    m0_read = 1'b0;
    #4;
    check_eq("rd_m0_rdv",   {31'd0, m0_readdatavalid}, 32'd1);
    check_eq("rd_m0_data",  m0_readdata,               32'hDEADBEEF);
    check_eq("rd_m1_rdv",   {31'd0, m1_readdatavalid}, 32'd0);
    step();
    check_eq("rd_m0_rdv_gone", {31'd0, m0_readdatavalid}, 32'd0);

    // Four cycles of write contention: m0, m1, m0, m1
    apply_reset();
    m0_write = 1'b1; m0_address = 11'h100; m0_writedata = 32'hAAAA0000;
    m1_write = 1'b1; m1_address = 11'h101; m1_writedata = 32'hBBBB1111;
    for (int i = 0; i < 4; i++) begin
      #4;
      check_eq($sformatf("wc_m0_wait%0d", i), {31'd0, m0_waitrequest}, (i % 2 == 0) ? 32'd0 : 32'd1);
      check_eq($sformatf("wc_m1_wait%0d", i), {31'd0, m1_waitrequest}, (i % 2 == 0) ? 32'd1 : 32'd0);
      check_eq($sformatf("wc_wdata%0d", i),   mem_writedata, (i % 2 == 0) ? 32'hAAAA0000 : 32'hBBBB1111);
      check_eq($sformatf("wc_wr%0d", i),      {31'd0, mem_write}, 32'd1);
      step();
    end
    idle_inputs();
    #4;
    check_eq("wc_cnt", {16'd0, contention_count}, 32'd4);
    step();

    // Partial write by m1 to 0x7FF, readback by m0
    m1_write = 1'b1; m1_address = 11'h7FF; m1_writedata = 32'h12345678; m1_byteenable = 4'b0011;
    #4;
    check_eq("be_m1_wait", {31'd0, m1_waitrequest}, 32'd0);
    check_eq("be_be",      {28'd0, mem_byteenable}, 32'h3);
    step();
    idle_inputs();
    m0_read = 1'b1; m0_address = 11'h7FF;
    step();
    idle_inputs();
    #4;
    check_eq("be_m0_rdv",  {31'd0, m0_readdatavalid}, 32'd1);
    check_eq("be_m0_data", m0_readdata, 32'hFFFF5678);
    step();

    // Simultaneous reads: m0 at t, m1 at t+1, returned in order
    apply_reset();
    m0_read = 1'b1; m0_address = 11'h010;
    m1_read = 1'b1; m1_address = 11'h020;
    #4;
    check_eq("rr_t_m0_wait", {31'd0, m0_waitrequest}, 32'd0);
    check_eq("rr_t_m1_wait", {31'd0, m1_waitrequest}, 32'd1);
    step();
    m0_read = 1'b0;
    #4;
    check_eq("rr_t1_m1_wait", {31'd0, m1_waitrequest},   32'd0);
    check_eq("rr_t1_m0_rdv",  {31'd0, m0_readdatavalid}, 32'd1);
    check_eq("rr_t1_m1_rdv",  {31'd0, m1_readdatavalid}, 32'd0);
    check_eq("rr_t1_m0_data", m0_readdata, 32'h11110010);
    step();
    m1_read = 1'b0;
    #4;
    check_eq("rr_t2_m1_rdv",  {31'd0, m1_readdatavalid}, 32'd1);
    check_eq("rr_t2_m0_rdv",  {31'd0, m0_readdatavalid}, 32'd0);
    check_eq("rr_t2_m1_data", m1_readdata, 32'h22220020);
    check_eq("rr_cnt",        {16'd0, contention_count}, 32'd1);
    step();

    // Reset right after an accepted read drops the return
    m0_read = 1'b1; m0_address = 11'h005;
    step();
    m0_read = 1'b0;
    reset = 1'b1;
    #4;
    check_eq("mr_m0_rdv", {31'd0, m0_readdatavalid}, 32'd0);
    check_eq("mr_m1_rdv", {31'd0, m1_readdatavalid}, 32'd0);
    step();
    reset = 1'b0;
    m0_read = 1'b1; m0_address = 11'h010;
    m1_read = 1'b1; m1_address = 11'h020;
    #4;
    check_eq("mr_m0_wait", {31'd0, m0_waitrequest}, 32'd0);
    check_eq("mr_m1_wait", {31'd0, m1_waitrequest}, 32'd1);
    step();
    idle_inputs();
    step();

    // Counter saturation and clear priority
    apply_reset();
    m0_write = 1'b1; m0_address = 11'h200;
    m1_write = 1'b1; m1_address = 11'h201;
    repeat (65535) step();
    check_eq("sat_reach", {16'd0, contention_count}, 32'h0000FFFF);
    repeat (3) step();
    check_eq("sat_hold",  {16'd0, contention_count}, 32'h0000FFFF);
    contention_clear = 1'b1;
    step();
    check_eq("clr_zero",  {16'd0, contention_count}, 32'h0);
    contention_clear = 1'b0;
    step();
    check_eq("clr_resume", {16'd0, contention_count}, 32'h1);
    idle_inputs();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/onchip_mem_arbiter.md
Name: onchip_mem_arbiter

Overview:
Two-requester arbiter that shares one single-port on-chip RAM (2048 x 32, byte-enabled, unregistered output, 1-cycle read latency) between the Nios data master (m0) and the ADC sample writer (m1). It presents an Avalon-MM slave with waitrequest and readdatavalid to each requester. It drives the RAM's address, byteenable, chipselect, write, writedata and clken. Round-robin arbitration runs at one access per clock, and a saturating contention counter supports debug.

Parameters:
ADDR_W, 11, word address width (2048 words)
DATA_W, 32, data width; byteenable width BE_W = DATA_W/8
CNT_W, 16, width of the contention counter

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
m0_address  in  ADDR_W  requester 0 word address
m0_read  in  1  requester 0 read request
m0_write  in  1  requester 0 write request
m0_byteenable  in  BE_W  requester 0 byte lanes
m0_writedata  in  DATA_W  requester 0 write data
m0_waitrequest  out  1  high = request not accepted this cycle
m0_readdata  out  DATA_W  requester 0 read data
m0_readdatavalid  out  1  m0_readdata valid this cycle
m1_* (same eight signals as m0_*)  -  -  requester 1
mem_address  out  ADDR_W  to RAM
mem_byteenable  out  BE_W  to RAM
mem_chipselect  out  1  to RAM
mem_write  out  1  to RAM (RAM wren = chipselect & write)
mem_writedata  out  DATA_W  to RAM
mem_clken  out  1  RAM clock enable
mem_readdata  in  DATA_W  from RAM, valid 1 cycle after a read is issued
contention_count  out  CNT_W  cycles in which both requesters requested
contention_clear  in  1  synchronous clear of contention_count

Behaviour:
- State registers:
  - last_grant: 1 bit, reset value 1, so m0 wins the first conflict.
  - rd_pending: 1 bit, reset 0.
  - rd_owner: 1 bit, reset 0.
  - contention_count: reset 0.
- Request decoding:
  - reqN = mN_read | mN_write.
  - If read and write are both asserted together, treat it as a write.
- Grant logic (combinational, same cycle):
  - Only one requester: it is granted.
  - Both requesting: the requester other than last_grant is granted.
  - Neither requesting: no grant.
  - last_grant updates only on cycles with a grant.
- Waitrequest:
  - mN_waitrequest = reqN & ~grantN.
  - While reset is asserted, both waitrequests are 1 and both grants are 0.
  - Requesters must hold address, data and command until waitrequest is low (Avalon rule); the arbiter does not latch them.
- RAM drive:
  - Granted cycle: mem_* mux the granted requester's address, byteenable and writedata.
  - mem_chipselect = 1; mem_write = granted write.
  - No grant: mem_chipselect = 0, mem_write = 0, address and data don't-care (hold the m0 mux).
  - mem_clken = ~reset.
- Read return:
  - Accepting a read sets rd_pending = 1 and rd_owner = granted index on the next edge; otherwise rd_pending = 0.
  - mN_readdatavalid = rd_pending & (rd_owner == N).
  - mN_readdata = mem_readdata, passed through unregistered.
  - Latency is exactly 1 cycle from the accept edge to readdatavalid.
  - Back-to-back reads sustain 1 per cycle; alternating owners are returned in order.
- Writes: complete on the accept cycle; no response.
- Contention counter:
  - Increments when req0 & req1, and saturates at all-ones.
  - contention_clear has priority over increment.
- Reset mid-operation:
  - Asynchronous reset clears rd_pending, so an in-flight readdatavalid is dropped.
  - last_grant returns to 1.
- Read-during-write: the same address written by one requester and read by the other on a later cycle returns the new data. Only one access per cycle exists, so there is no same-cycle hazard.

Test Plan:
- Reset, then m0 reads address 0x005 (RAM preloaded 0xDEADBEEF) -> m0_waitrequest low in the same cycle; m0_readdatavalid=1 with 0xDEADBEEF one cycle later; m1_readdatavalid stays 0.
- m0 and m1 both write continuously for 4 cycles -> grants alternate m0, m1, m0, m1; each loser sees waitrequest=1; contention_count=4.
- m1 writes 0x12345678 with byteenable=4'b0011 to 0x7FF, then m0 reads 0x7FF (prior contents 0xFFFFFFFF) -> m0 gets 0xFFFF5678.
- m0 read to 0x010 and m1 read to 0x020 requested together -> m0 accepted cycle t, m1 at t+1; m0 readdatavalid at t+1, m1 readdatavalid at t+2, each with the correct data.
- Reset asserted in the cycle after an accepted read -> no readdatavalid; after release, m0 wins the first conflict.
- contention_count forced to 0xFFFF with continued contention -> holds 0xFFFF; contention_clear pulse -> 0 on the next edge, even with contention in the same cycle.
